// File: rtl/sha_arb_pkg.sv
// Shared definitions for the SHA-256 core arbiter.
//   sha_arb_state_e : arbiter FSM states
//   DEF_NREQ        : default number of requesters
//   DEF_LOAD_CYCLES : default cycles per block load
//   TIMEOUT_MAX     : WAIT_OUT watchdog limit (used only with SHA_ARB_TIMEOUT_EN)
package sha_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      LOAD,
      WAIT_OUT,
      DRAIN
   } sha_arb_state_e;

   localparam int         DEF_NREQ        = 4;
   localparam int         DEF_LOAD_CYCLES = 64;
   localparam logic [7:0] TIMEOUT_MAX     = 8'd255;

endpackage

// File: rtl/sha_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : index at which the search starts (wrapping at NREQ-1)
//   grant : one-hot winner, zero when nothing requests
//   valid : at least one request present
module sha_rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic            valid
);

   int best_dist;
   int cur_dist;

   // The requester with the smallest upward distance from ptr wins.
   always_comb begin
      grant     = '0;
      best_dist = NREQ;
      cur_dist  = 0;
      for (int k = 0; k < NREQ; k++) begin
         cur_dist = (k >= int'(ptr)) ? (k - int'(ptr)) : (k + NREQ - int'(ptr));
         if (req[k] && (cur_dist < best_dist)) begin
            best_dist = cur_dist;
            grant     = '0;
            grant[k]  = 1'b1;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/sha256_arbiter.sv
// Round-robin arbiter handing one SHA-256 core to NREQ requesters, one
// whole message at a time, and sequencing the core's block loads.
//   clk, reset         : clock, synchronous active-high reset
//   req, last_blk      : per-requester ownership request / final-block flag
//   core_output_enable : core digest-valid window
//   gnt                : one-hot owner, also the data-mux select
//   core_first_block   : pulse at START of a message's first block
//   core_last_block    : pulse at START of a message's final block
//   load_cnt           : word index during LOAD, 0 elsewhere
//   done, err          : one-cycle completion / timeout pulses to the owner
// Optional feature: define SHA_ARB_TIMEOUT_EN to build a WAIT_OUT watchdog
// that releases the core with an err pulse; otherwise err is tied to 0.
module sha256_arbiter
   import sha_arb_pkg::*;
#(
   parameter int NREQ        = DEF_NREQ,
   parameter int LOAD_CYCLES = DEF_LOAD_CYCLES
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] last_blk,
   input  logic            core_output_enable,
   output logic [NREQ-1:0] gnt,
   output logic            core_first_block,
   output logic            core_last_block,
   output logic [6:0]      load_cnt,
   output logic [NREQ-1:0] done,
   output logic [NREQ-1:0] err
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   sha_arb_state_e  state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic            blk_is_last_q, blk_is_last_d;
   logic            first_q, first_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] done_q, done_d;
   logic [6:0]      load_cnt_q, load_cnt_d;
   logic [NREQ-1:0] pick_grant;
   logic            pick_valid;
   logic [PW-1:0]   pick_idx;
   logic [PW-1:0]   ptr_after;
`ifdef SHA_ARB_TIMEOUT_EN
   logic [7:0]      wd_q, wd_d;
   logic [NREQ-1:0] err_q, err_d;
`endif

   sha_rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .valid (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (pick_grant[k]) begin
            pick_idx = PW'(k);
         end
      end
   end

   // Search start for the next arbitration: one past the releasing owner.
   assign ptr_after = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      owner_d       = owner_q;
      blk_is_last_d = blk_is_last_q;
      first_d       = first_q;
      gnt_d         = gnt_q;
      done_d        = '0;
      load_cnt_d    = '0;
`ifdef SHA_ARB_TIMEOUT_EN
      wd_d          = wd_q;
      err_d         = '0;
`endif
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               owner_d = pick_idx;
               gnt_d   = pick_grant;
               first_d = 1'b1;
               state_d = START;
            end
         end
         START: begin
            blk_is_last_d = last_blk[owner_q];
            first_d       = 1'b0;
            state_d       = LOAD;
         end
         LOAD: begin
            if (load_cnt_q == 7'(LOAD_CYCLES - 1)) begin
               state_d = blk_is_last_q ? WAIT_OUT : START;
`ifdef SHA_ARB_TIMEOUT_EN
               wd_d    = '0;
`endif
            end else begin
               load_cnt_d = load_cnt_q + 7'd1;
            end
         end
         WAIT_OUT: begin
            if (core_output_enable) begin
               state_d = DRAIN;
`ifdef SHA_ARB_TIMEOUT_EN
            // wd_q counts completed WAIT_OUT cycles; the 255th one fires
            // so the registered err lands 255 cycles after entry.
            end else if (wd_q == TIMEOUT_MAX - 8'd1) begin
               err_d   = gnt_q;
               gnt_d   = '0;
               ptr_d   = ptr_after;
               state_d = IDLE;
            end else begin
               wd_d = wd_q + 8'd1;
`endif
            end
         end
         DRAIN: begin
            // Falling edge of the digest window closes the message.
            if (!core_output_enable) begin
               done_d  = gnt_q;
               gnt_d   = '0;
               ptr_d   = ptr_after;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         owner_q       <= '0;
         blk_is_last_q <= 1'b0;
         first_q       <= 1'b0;
         gnt_q         <= '0;
         done_q        <= '0;
         load_cnt_q    <= '0;
`ifdef SHA_ARB_TIMEOUT_EN
         wd_q          <= '0;
         err_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         owner_q       <= owner_d;
         blk_is_last_q <= blk_is_last_d;
         first_q       <= first_d;
         gnt_q         <= gnt_d;
         done_q        <= done_d;
         load_cnt_q    <= load_cnt_d;
`ifdef SHA_ARB_TIMEOUT_EN
         wd_q          <= wd_d;
         err_q         <= err_d;
`endif
      end
   end

   assign gnt              = gnt_q;
   assign done             = done_q;
   assign load_cnt         = load_cnt_q;
   assign core_first_block = (state_q == START) && first_q;
   assign core_last_block  = (state_q == START) && last_blk[owner_q];
`ifdef SHA_ARB_TIMEOUT_EN
   assign err              = err_q;
`else
   assign err              = '0;
`endif

endmodule

// File: tb/tb_sha256_arbiter.sv
// Self-checking bench for sha256_arbiter (default parameters). Expected
// owners come from a round-robin model over an integer pointer; message
// timing (START, 64 LOAD words, digest window, done) from the protocol rules.
module tb_sha256_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] last_blk;
   logic       core_output_enable;
   logic [3:0] gnt;
   logic       core_first_block;
   logic       core_last_block;
   logic [6:0] load_cnt;
   logic [3:0] done;
   logic [3:0] err;

   int total = 0;
   int bad   = 0;
   int m_ptr = 0;

   sha256_arbiter dut (
      .clk                (clk),
      .reset              (reset),
      .req                (req),
      .last_blk           (last_blk),
      .core_output_enable (core_output_enable),
      .gnt                (gnt),
      .core_first_block   (core_first_block),
      .core_last_block    (core_last_block),
      .load_cnt           (load_cnt),
      .done               (done),
      .err                (err)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: sim time exceeded, bench did not finish");
      $fatal(1);
   end

   function automatic int rr_model(input logic [3:0] r, input int p);
      for (int d = 0; d < 4; d++) begin
         if (r[(p + d) % 4]) return (p + d) % 4;
      end
      return 0;
   endfunction

   // Drives one complete message and checks it. drain_len < 0 means the
   // digest window never opens (timeout scenario).
   task automatic do_message(input logic [3:0] r, input int nblk, input int drain_len,
                             input bit keep_req, output logic [3:0] seen);
      int w;
      logic [3:0] oh;
      logic [3:0] rnd;
      int n;
      int wait_n;
      w  = rr_model(r, m_ptr);
      oh = 4'b0001 << w;
      total++;
      if (gnt !== 4'b0) begin bad++; $display("FAIL idle_gnt: got %b want 0000", gnt); end
      req = r;
      rnd = 4'($urandom);
      last_blk = (rnd & ~oh) | ((nblk == 1) ? oh : 4'b0);
      core_output_enable = 1'b0;
      @(posedge clk); #1;
      seen = gnt;
      if (!keep_req) req = 4'($urandom);
      for (int b = 0; b < nblk; b++) begin
         total++;
         if (gnt !== oh) begin bad++; $display("FAIL start_gnt: blk %0d got %b want %b", b, gnt, oh); end
         total++;
         if (core_first_block !== (b == 0)) begin
            bad++; $display("FAIL first_block: blk %0d got %b want %b", b, core_first_block, (b == 0));
         end
         total++;
         if (core_last_block !== (b == nblk - 1)) begin
            bad++; $display("FAIL last_block: blk %0d got %b want %b", b, core_last_block, (b == nblk - 1));
         end
         @(posedge clk); #1;
         for (int c = 0; c < 64; c++) begin
            total++;
            if (load_cnt !== 7'(c) || gnt !== oh || core_first_block !== 1'b0 || core_last_block !== 1'b0) begin
               bad++;
               $display("FAIL load: got cnt=%0d gnt=%b fb=%b lb=%b want cnt=%0d gnt=%b fb=0 lb=0",
                        load_cnt, gnt, core_first_block, core_last_block, c, oh);
            end
            // A digest-valid blip during LOAD must be ignored.
            core_output_enable = (c == 10);
            if (c == 63) begin
               rnd = 4'($urandom);
               last_blk = (rnd & ~oh) | ((b + 1 == nblk - 1) ? oh : 4'b0);
            end
            @(posedge clk); #1;
         end
      end
      core_output_enable = 1'b0;
      total++;
      if (load_cnt !== 7'd0 || gnt !== oh || done !== 4'b0) begin
         bad++; $display("FAIL wait_entry: got cnt=%0d gnt=%b done=%b want cnt=0 gnt=%b done=0000",
                         load_cnt, gnt, done, oh);
      end
      if (drain_len < 0) begin
`ifdef SHA_ARB_TIMEOUT_EN
         n = 0;
         while (err === 4'b0 && n < 300) begin @(posedge clk); #1; n++; end
         total++;
         if (n != 255) begin bad++; $display("FAIL timeout_cycles: got %0d want 255", n); end
         total++;
         if (err !== oh || gnt !== 4'b0 || done !== 4'b0) begin
            bad++; $display("FAIL timeout_pulse: got err=%b gnt=%b done=%b want err=%b gnt=0000 done=0000",
                            err, gnt, done, oh);
         end
         m_ptr = (w + 1) % 4;
         req = keep_req ? r : 4'b0;
         return;
`else
         n = 0;
         repeat (300) begin
            @(posedge clk); #1;
            if (err !== 4'b0 || gnt !== oh) n++;
         end
         total++;
         if (n != 0) begin bad++; $display("FAIL no_timeout: got %0d bad cycles want 0", n); end
         drain_len = 1;
`endif
      end
      wait_n = $urandom_range(0, 4);
      repeat (wait_n) begin
         @(posedge clk); #1;
         total++;
         if (gnt !== oh || done !== 4'b0) begin
            bad++; $display("FAIL wait_hold: got gnt=%b done=%b want gnt=%b done=0000", gnt, done, oh);
         end
      end
      core_output_enable = 1'b1;
      repeat (drain_len) begin
         @(posedge clk); #1;
         total++;
         if (gnt !== oh || done !== 4'b0 || err !== 4'b0) begin
            bad++; $display("FAIL drain_hold: got gnt=%b done=%b err=%b want gnt=%b done=0000 err=0000",
                            gnt, done, err, oh);
         end
      end
      core_output_enable = 1'b0;
      @(posedge clk); #1;
      total++;
      if (done !== oh || gnt !== 4'b0 || err !== 4'b0) begin
         bad++; $display("FAIL done_pulse: got done=%b gnt=%b err=%b want done=%b gnt=0000 err=0000",
                         done, gnt, err, oh);
      end
      m_ptr = (w + 1) % 4;
      req = keep_req ? r : 4'b0;
      $display("msg: req=%b blocks=%0d owner=%0d", r, nblk, w);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) begin
         req = 4'($urandom);
         last_blk = 4'($urandom);
         core_output_enable = 1'($urandom);
         @(posedge clk); #1;
         total++;
         if (gnt !== 4'b0 || done !== 4'b0 || err !== 4'b0 || load_cnt !== 7'd0 ||
             core_first_block !== 1'b0 || core_last_block !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: got gnt=%b done=%b err=%b cnt=%0d fb=%b lb=%b want all 0",
                            gnt, done, err, load_cnt, core_first_block, core_last_block);
         end
      end
      req = 4'b0; last_blk = 4'b0; core_output_enable = 1'b0;
      reset = 1'b0;
      m_ptr = 0;
      $display("reset: checked");
   endtask

   task automatic test_idle();
      req = 4'b0;
      for (int i = 0; i < 6; i++) begin
         core_output_enable = (i < 3);
         @(posedge clk); #1;
         total++;
         if (gnt !== 4'b0 || done !== 4'b0 || load_cnt !== 7'd0) begin
            bad++; $display("FAIL idle_stay: got gnt=%b done=%b cnt=%0d want 0", gnt, done, load_cnt);
         end
      end
      core_output_enable = 1'b0;
      $display("idle: checked");
   endtask

   task automatic test_single_request();
      logic [3:0] seen;
      do_message(4'b0001, 1, 64, 1'b0, seen);
      total++;
      if (seen !== 4'b0001) begin bad++; $display("FAIL single_gnt: got %b want 0001", seen); end
      @(posedge clk); #1;
      total++;
      if (done !== 4'b0 || gnt !== 4'b0) begin
         bad++; $display("FAIL done_one_cycle: got done=%b gnt=%b want 0000", done, gnt);
      end
   endtask

   task automatic test_multi_block();
      logic [3:0] seen;
      do_message(4'b0100, 3, 5, 1'b0, seen);
      total++;
      if (seen !== 4'b0100) begin bad++; $display("FAIL multi_gnt: got %b want 0100", seen); end
   endtask

   task automatic test_fairness();
      logic [3:0] seen;
      logic [3:0] exp_seq [5];
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      reset = 1'b1; req = 4'b0;
      @(posedge clk); #1;
      reset = 1'b0; m_ptr = 0;
      for (int i = 0; i < 5; i++) begin
         do_message(4'b1111, 1, 3, 1'b1, seen);
         total++;
         if (seen !== exp_seq[i]) begin
            bad++; $display("FAIL fairness: grant %0d got %b want %b", i, seen, exp_seq[i]);
         end
      end
      req = 4'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_mid_reset();
      int n;
      req = 4'b0100; last_blk = 4'b0100; core_output_enable = 1'b0;
      @(posedge clk); #1;
      n = 0;
      while (load_cnt !== 7'd30 && n < 100) begin @(posedge clk); #1; n++; end
      total++;
      if (load_cnt !== 7'd30) begin bad++; $display("FAIL reach_cnt30: got %0d want 30", load_cnt); end
      reset = 1'b1; req = 4'b0;
      @(posedge clk); #1;
      total++;
      if (gnt !== 4'b0 || done !== 4'b0 || err !== 4'b0 || load_cnt !== 7'd0 ||
          core_first_block !== 1'b0 || core_last_block !== 1'b0) begin
         bad++; $display("FAIL midreset_outputs: got gnt=%b done=%b err=%b cnt=%0d want all 0",
                         gnt, done, err, load_cnt);
      end
      reset = 1'b0; m_ptr = 0;
      n = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (done !== 4'b0 || err !== 4'b0 || gnt !== 4'b0) n++;
      end
      total++;
      if (n != 0) begin bad++; $display("FAIL midreset_quiet: got %0d bad cycles want 0", n); end
      req = 4'b1111;
      @(posedge clk); #1;
      total++;
      if (gnt !== 4'b0001) begin bad++; $display("FAIL midreset_ptr: got %b want 0001", gnt); end
      reset = 1'b1; req = 4'b0;
      @(posedge clk); #1;
      reset = 1'b0; m_ptr = 0;
      $display("mid_reset: checked");
   endtask

   task automatic test_timeout();
      logic [3:0] seen;
      do_message(4'b1000, 1, -1, 1'b0, seen);
      @(posedge clk); #1;
      total++;
      if (err !== 4'b0 || gnt !== 4'b0 || done !== 4'b0) begin
         bad++; $display("FAIL after_timeout: got err=%b gnt=%b done=%b want 0000", err, gnt, done);
      end
   endtask

   task automatic test_random();
      logic [3:0] seen;
      logic [3:0] r;
      for (int i = 0; i < 8; i++) begin
         r = 4'($urandom_range(1, 15));
         do_message(r, $urandom_range(1, 3), $urandom_range(1, 8), 1'($urandom), seen);
      end
      req = 4'b0;
   endtask

   initial begin
      reset = 1'b1;
      req = 4'b0;
      last_blk = 4'b0;
      core_output_enable = 1'b0;
      test_reset();
      test_idle();
      test_single_request();
      test_multi_block();
      test_fairness();
      test_mid_reset();
      test_timeout();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sha256_arbiter.md
SHA256_ARBITER -- requirements
Module: sha256_arbiter

Interface
REQ-001 The block SHALL have a parameter NREQ, default 4, giving the number of requesters sharing one SHA-256 core.
REQ-002 The block SHALL have a parameter LOAD_CYCLES, default 64, giving the number of cycles per block load.
REQ-003 The block SHALL have a port clk, input, 1 bit, the clock.
REQ-004 The block SHALL have a port reset, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have a port req, input, NREQ bits, the per-requester request for core ownership.
REQ-006 The block SHALL have a port last_blk, input, NREQ bits, meaning the requester's current block is the final block of its message.
REQ-007 The block SHALL have a port core_output_enable, input, 1 bit, the core's digest-valid window.
REQ-008 The block SHALL have a port gnt, output, NREQ bits, the one-hot owner grant that also steers the data mux.
REQ-009 The block SHALL have a port core_first_block, output, 1 bit, a one-cycle pulse at the start of a message's first block.
REQ-010 The block SHALL have a port core_last_block, output, 1 bit, a one-cycle pulse at the start of a message's last block.
REQ-011 The block SHALL have a port load_cnt, output, 7 bits, the word index within the block being loaded.
REQ-012 The block SHALL have a port done, output, NREQ bits, a one-cycle pulse to the owner once its digest window has closed.
REQ-013 The block SHALL have a port err, output, NREQ bits, a one-cycle timeout pulse to the owner.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, START, LOAD, WAIT_OUT and DRAIN.
REQ-015 IDLE SHALL pick a winner by round-robin when req is non-zero: search from ptr upward, wrapping at NREQ-1.
REQ-016 In IDLE the winner SHALL register as owner, gnt SHALL assert in the next cycle and the FSM SHALL move to START.
REQ-017 START SHALL last one cycle.
REQ-018 In START, core_first_block SHALL be 1 only for the message's first block.
REQ-019 In START, core_last_block SHALL equal last_blk[owner] sampled in that cycle, with the sampled value held as blk_is_last.
REQ-020 After START the FSM SHALL move to LOAD.
REQ-021 In LOAD, load_cnt SHALL count 0..LOAD_CYCLES-1.
REQ-022 At LOAD_CYCLES-1 the FSM SHALL go to WAIT_OUT if blk_is_last, else to START for the next block with core_first_block=0.
REQ-023 In WAIT_OUT the FSM SHALL stay until core_output_enable=1, then move to DRAIN.
REQ-024 In DRAIN the FSM SHALL stay while core_output_enable=1.
REQ-025 On the falling edge of core_output_enable: done[owner]=1 for one cycle, gnt=0, ptr=(owner+1) mod NREQ, and the FSM returns to IDLE.
REQ-026 gnt SHALL stay constant and one-hot from START through DRAIN, with no preemption.
REQ-027 Changes of req[owner] after grant SHALL be ignored.
REQ-028 A new request arriving mid-message SHALL wait for IDLE.
REQ-029 Arbitration SHALL restart from IDLE with one dead cycle after done, so that back-to-back owners are separated by at least one IDLE cycle.
REQ-030 load_cnt SHALL be 0 outside LOAD.
REQ-031 load_cnt SHALL be 7 bits with no wrap within LOAD.
REQ-032 If req is all zeros in IDLE, the FSM SHALL stay in IDLE.
REQ-033 With simultaneous requests, the requester closest to ptr at or above it SHALL win.
REQ-034 A core_output_enable pulse seen in IDLE, START or LOAD SHALL be ignored.

Reset
REQ-035 Reset SHALL set state=IDLE, ptr=0, owner=0 and blk_is_last=0.
REQ-036 Reset SHALL set every output to 0.
REQ-037 Reset asserted mid-message SHALL abort the message without a done or err pulse.

Configuration
REQ-038 With SHA_ARB_TIMEOUT_EN defined, an 8-bit watchdog SHALL count cycles spent in WAIT_OUT.
REQ-039 With SHA_ARB_TIMEOUT_EN defined, a count of 255 SHALL pulse err[owner] for one cycle, release gnt, advance ptr and return to IDLE without done.
REQ-040 With SHA_ARB_TIMEOUT_EN defined, the watchdog SHALL clear on entry to WAIT_OUT.
REQ-041 Without SHA_ARB_TIMEOUT_EN defined, no watchdog SHALL be built, err SHALL be tied to 0, and WAIT_OUT SHALL wait indefinitely.

Structure
REQ-042 Package sha_arb_pkg SHALL hold the state enum, the default NREQ, the default LOAD_CYCLES and TIMEOUT_MAX=255.
REQ-043 Sub-module sha_rr_pick SHALL be purely combinational, taking req and ptr and returning a one-hot winner and a valid flag.
REQ-044 The arbiter SHALL contain the FSM, the counters and the registers.

Verification
REQ-045 Single request: req=0001 with last_blk=0001 -> gnt=0001, a core_first_block and core_last_block pulse in the same START cycle, load_cnt runs 0..63, then WAIT_OUT.
REQ-046 Done pulse: drive core_output_enable high for 64 cycles -> done[0] pulses 1 cycle after the fall, then IDLE.
REQ-047 Multi-block: req=0100 with last_blk low for 2 blocks, then high -> 3 START pulses, first_block only on the first, last_block only on the third, gnt=0100 throughout.
REQ-048 Fairness: req=1111 held constantly -> grants in order 0001, 0010, 0100, 1000, 0001, and none is granted twice before all have been served.
REQ-049 Reset mid-LOAD: assert reset at load_cnt=30 -> all outputs 0 next cycle, ptr=0, and neither done nor err pulses.
REQ-050 Timeout, with SHA_ARB_TIMEOUT_EN defined: never drive core_output_enable -> err[owner] pulses 255 cycles after WAIT_OUT entry, then IDLE. Without the macro, err stays 0.
